// File: rtl/spi_ram_mon_pkg.sv
// spi_ram_mon_pkg: command/state encodings and error-bit indices for the SPI-RAM monitor
package spi_ram_mon_pkg;
  typedef enum logic [1:0] {WR_ADDR = 2'd0, WR_DATA = 2'd1, RD_ADDR = 2'd2, RD_DATA = 2'd3} cmd_e;
  typedef enum logic [1:0] {IDLE = 2'd0, WR_PEND = 2'd1, RD_PEND = 2'd2, RD_WAIT = 2'd3} mon_state_e;
  localparam int E_SEQ  = 0;
  localparam int E_LATE = 1;
  localparam int E_SPUR = 2;
  localparam int E_DATA = 3;
  localparam int E_RST  = 4;
endpackage

// File: rtl/spi_ram_mon_shadow.sv
// spi_ram_mon_shadow: shadow copy of the RAM with per-address valid bits
module spi_ram_mon_shadow #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);
  logic [DATA_W-1:0]      mem [2**DATA_W];
  logic [2**DATA_W-1:0]   valid;
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid <= '0;
    else if (we) valid[waddr] <= 1'b1;
  assign rdata  = mem[raddr];
  assign rvalid = valid[raddr];
endmodule

// File: rtl/spi_ram_protocol_monitor.sv
// spi_ram_protocol_monitor: passive checker of command sequencing, tx_valid timing and read data
module spi_ram_protocol_monitor
  import spi_ram_mon_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 8,
  parameter bit CHECK_DATA = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] dout,
  input  logic              tx_valid,
  input  logic              err_clr,
  output logic [4:0]        err_flags,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [1:0]        mon_state
);
  mon_state_e        state_q, state_d;
  logic [DATA_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, sh_data;
  logic              first_q, sup_q, sup_d, sh_we, sh_valid, legal;
  logic [4:0]        fire;
  logic [CNT_W-1:0]  cnt_base;
  cmd_e              cmd;
  logic [DATA_W-1:0] field;
  assign cmd   = cmd_e'(din[DATA_W+1:DATA_W]);
  assign field = din[DATA_W-1:0];
  assign legal = (state_q == IDLE    && (cmd == WR_ADDR || cmd == RD_ADDR)) ||
                 (state_q == WR_PEND && cmd == WR_DATA) ||
                 (state_q == RD_PEND && cmd == RD_DATA);
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    sup_d     = sup_q;
    sh_we     = 1'b0;
    fire      = '0;
    if (state_q == RD_WAIT) begin
      fire[E_LATE] = !tx_valid;
      fire[E_DATA] = tx_valid && !sup_q && sh_valid && dout != sh_data;
      state_d      = IDLE;
    end
    // Every accepted command, legal or not, lands in the state it implies
    if (rx_valid) begin
      fire[E_SEQ] = !legal;
      state_d     = cmd == WR_ADDR ? WR_PEND : cmd == WR_DATA ? IDLE : cmd == RD_ADDR ? RD_PEND : RD_WAIT;
      wr_addr_d   = cmd == WR_ADDR ? field : wr_addr_q;
      rd_addr_d   = cmd == RD_ADDR ? field : rd_addr_q;
      sup_d       = cmd == RD_DATA && state_q != RD_PEND;
      sh_we       = cmd == WR_DATA && state_q == WR_PEND;
    end
    fire[E_SPUR] = tx_valid && state_q != RD_WAIT && !first_q;
    fire[E_RST]  = first_q && (tx_valid || dout != '0);
  end
  assign cnt_base = err_clr ? '0 : err_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      sup_q     <= 1'b0;
      first_q   <= 1'b1;
      err_flags <= '0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      sup_q     <= sup_d;
      first_q   <= 1'b0;
      err_flags <= (err_clr ? 5'b0 : err_flags) | fire;
      err_pulse <= |fire;
      err_cnt   <= (|fire && !(&cnt_base)) ? cnt_base + CNT_W'(1) : cnt_base;
    end
  generate
    if (CHECK_DATA) begin : g_shadow
      spi_ram_mon_shadow #(.DATA_W(DATA_W)) u_shadow (
        .clk(clk), .rst_n(rst_n), .we(sh_we), .waddr(wr_addr_q), .wdata(field),
        .raddr(rd_addr_q), .rdata(sh_data), .rvalid(sh_valid)
      );
    end else begin : g_no_shadow
      assign sh_data  = '0;
      assign sh_valid = 1'b0;
    end
  endgenerate
  assign mon_state = state_q;
endmodule

// File: doc/spi_ram_protocol_monitor.md
# spi_ram_protocol_monitor

- Synthesisable, parametrised protocol monitor for the SPI slave ↔ single-port RAM link. It generalises the fixed 8-bit property checker into RTL that runs in simulation, emulation and silicon debug.
- It tracks the 2-bit command stream on `din` with an FSM and checks `tx_valid` timing and post-reset values.
- It compares read data against a shadow memory and reports violations through sticky flags, a pulse and a saturating counter.
- It is purely passive: it observes the RAM's inputs and outputs and drives nothing on the link.

## Interface
- `DATA_W`, default 8: address/data field width. `din` is `DATA_W+2` bits; shadow depth is 2**DATA_W.
- `CNT_W`, default 8: error counter width.
- `CHECK_DATA`, default 1: enables the shadow memory and the read-data check. When 0, the shadow is not built.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `din`  in  DATA_W+2  RAM input. `[DATA_W+1:DATA_W]` is the command, `[DATA_W-1:0]` is the field.
- `rx_valid`  in  1  `din` qualifier. A command is accepted only on cycles with `rx_valid=1`.
- `dout`  in  DATA_W  RAM read data.
- `tx_valid`  in  1  RAM read-data valid.
- `err_clr`  in  1  synchronous clear of `err_flags` and `err_cnt`.
- `err_flags`  out  5  sticky flags: [0] SEQ, [1] LATE, [2] SPUR, [3] DATA, [4] RST.
- `err_pulse`  out  1  high for one cycle when any error fires.
- `err_cnt`  out  CNT_W  count of error cycles, saturating at 2**CNT_W-1.
- `mon_state`  out  2  current FSM state.

## Operation
- Command encoding: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- FSM states: IDLE=0, WR_PEND=1, RD_PEND=2, RD_WAIT=3.
- Legal accepted commands per state:
  - IDLE: WR_ADDR → WR_PEND (latch wr_addr); RD_ADDR → RD_PEND (latch rd_addr).
  - WR_PEND: WR_DATA → IDLE; writes shadow[wr_addr]=field and sets its valid bit.
  - RD_PEND: RD_DATA → RD_WAIT.
  - RD_WAIT: no command is legal. The state is left after exactly one cycle.
- Illegal accepted command:
  - Set SEQ.
  - Resynchronise to the state the command implies: WR_ADDR→WR_PEND, RD_ADDR→RD_PEND, WR_DATA→IDLE with no shadow write, RD_DATA→RD_WAIT with the data check suppressed.
  - The address latch updates for WR_ADDR and RD_ADDR.
- In RD_WAIT:
  - `tx_valid=1`: if the data check is enabled, shadow[rd_addr] is valid and `dout` differs from it, set DATA.
  - `tx_valid=0`: set LATE.
  - Either way, go to IDLE unless a command is accepted the same cycle (apply the illegal-command rule).
- SPUR: `tx_valid=1` in any state other than RD_WAIT. This includes a second consecutive `tx_valid` cycle.
- RST: on the first `clk` edge after `rst_n` deasserts, `dout!=0` or `tx_valid!=0` sets RST. SPUR is suppressed on that cycle.
- Shadow valid bits are all cleared by reset. Unwritten addresses are never checked.
- Counter: increments by 1 per cycle in which at least one flag fires, regardless of how many fire. It saturates and does not wrap.

## Timing
- Reset values: `err_flags`=0, `err_pulse`=0, `err_cnt`=0, `mon_state`=IDLE. The first-cycle marker is set to 1.
- Flags, `err_pulse` and `err_cnt` update on the clock edge that samples the violating cycle, so they are visible one cycle later.
- `tx_valid` is expected exactly one cycle after RD_DATA is accepted.
- `err_clr` together with a new error: the new flag is set, the other flags clear, and `err_cnt`=1.
- Reset mid-transaction: FSM returns to IDLE, latches clear, flags and counter clear, the RST check is re-armed, and no error is reported for the aborted transaction.

## Structure
- Package `spi_ram_mon_pkg` holds:
  - `cmd_e` (the four commands);
  - `mon_state_e`;
  - error-bit index localparams `E_SEQ`, `E_LATE`, `E_SPUR`, `E_DATA`, `E_RST`.
- Sub-module `spi_ram_mon_shadow`:
  - 2**DATA_W × DATA_W storage plus a valid-bit vector;
  - one write port and one combinational read port;
  - valid bits cleared by asynchronous reset;
  - instantiated only when `CHECK_DATA=1`.

## Test plan
- WR_ADDR 0x12, WR_DATA 0xA5, RD_ADDR 0x12, RD_DATA, then `tx_valid=1`, `dout`=0xA5 one cycle later → no flags, `err_cnt`=0, `mon_state` back at IDLE.
- Same sequence with `dout`=0x5A → DATA set, `err_pulse` high for 1 cycle, `err_cnt`=1. Repeat the read to an unwritten address 0x33 → no DATA.
- WR_ADDR followed by RD_ADDR → SEQ set, `mon_state`=RD_PEND. Then RD_DATA with no `tx_valid` next cycle → LATE set, `err_cnt`=2.
- `tx_valid` pulsed in IDLE, and `tx_valid` held for 2 cycles after a RD_DATA → SPUR set for each, `err_cnt` incremented once per offending cycle.
- Release reset with `dout`=0x01 → RST set, SPUR not set. Assert reset mid-WR_PEND → all outputs return to 0/IDLE.
- `CNT_W`=2 with 5 error cycles → `err_cnt` stays at 3. `err_clr` coinciding with a SEQ error → only SEQ set, `err_cnt`=1.
